axi4_lite_master_ctrl: RTL and testbench
========================================

Name: axi4_lite_master_ctrl

Overview:
- Sequences single AXI4-Lite transactions toward the data-memory AXI4-Lite slave on behalf of a simple command/response requester (processor load/store unit or debug port).
- Accepts one command at a time and drives the AW/W/B or AR/R channel handshakes in order.
- Returns the slave's data and response, or a timeout error if the slave stalls.

Parameters:
ADDRESS, 32, address width in bits
DATA_WIDTH, 32, data width in bits
TIMEOUT_CYCLES, 64, max cycles from command acceptance to response handshake; must be at least 4

Ports:
ACLK  input  1  clock, all logic on rising edge
ARESETN  input  1  synchronous active-low reset
cmd_valid  input  1  requester presents a command
cmd_ready  output  1  controller can accept a command
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDRESS  transaction address
cmd_wdata  input  DATA_WIDTH  write data
cmd_wstrb  input  4  write byte strobes
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  DATA_WIDTH  read data (0 for writes and timeouts)
rsp_resp  output  2  BRESP/RRESP from slave, 2'b10 on timeout
rsp_timeout  output  1  qualifies rsp_valid; transaction aborted
M_AWADDR  output  ADDRESS  write address
M_AWVALID  output  1  write address valid
M_AWREADY  input  1  write address ready
M_WDATA  output  DATA_WIDTH  write data
M_WSTRB  output  4  write strobes
M_WVALID  output  1  write data valid
M_WREADY  input  1  write data ready
M_BRESP  input  2  write response
M_BVALID  input  1  write response valid
M_BREADY  output  1  write response ready
M_ARADDR  output  ADDRESS  read address
M_ARVALID  output  1  read address valid
M_ARREADY  input  1  read address ready
M_RDATA  input  DATA_WIDTH  read data
M_RRESP  input  2  read response
M_RVALID  input  1  read data valid
M_RREADY  output  1  read data ready

Behaviour:
- Reset (ARESETN low at a rising ACLK edge):
  - State goes to IDLE.
  - All M_* valid/ready outputs, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata and the timeout counter go to 0.
  - Address/data registers go to 0.
  - cmd_ready is 0 while ARESETN is low.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- cmd_ready = ARESETN && state==IDLE. A command is accepted when cmd_valid && cmd_ready.
- On acceptance, addr, wdata and wstrb are registered and driven on M_AWADDR/M_ARADDR/M_WDATA/M_WSTRB until return to IDLE.
  - Write: next cycle WR_REQ, with M_AWVALID=1 and M_WVALID=1.
  - Read: next cycle RD_REQ, with M_ARVALID=1.
- WR_REQ:
  - M_AWVALID is held until AWVALID&&AWREADY, then cleared on the following edge. M_WVALID is handled independently the same way.
  - Once both handshakes have occurred (same cycle or any order), go to WR_RESP.
  - A valid is never deasserted before its handshake, except on timeout.
- WR_RESP: M_BREADY=1. On BVALID, register BRESP into rsp_resp, pulse rsp_valid for one cycle, rsp_rdata=0, return to IDLE.
- RD_REQ: M_ARVALID held until ARREADY handshake, then go to RD_RESP.
- RD_RESP: M_RREADY=1. On RVALID, register RDATA/RRESP, pulse rsp_valid, return to IDLE.
- rsp_valid is asserted on the edge following the B/R handshake and has no backpressure.
- Best-case latency (slave ready immediately), cycles after acceptance:
  - write: 1 cycle of AW/W, 1 cycle of B, rsp_valid on cycle 3.
  - read: same timing, AR then R.
- Timeout:
  - The counter clears on acceptance and increments every non-IDLE cycle.
  - If it reaches TIMEOUT_CYCLES-1 without the response handshake, on that edge: clear all valids and readies, pulse rsp_valid with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0, and return to IDLE.
  - If the response handshake and timeout coincide, the handshake wins (normal response).
- Slave response codes are passed through unmodified; rsp_timeout is the only error generated locally.
- A new command may be accepted in the cycle rsp_valid is high (state is already IDLE).
- Reset mid-transaction aborts immediately with no rsp_valid.

Test Plan:
- Write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF, slave always ready, BRESP 2'b00 → AW/W valid 1 cycle, BREADY 1 cycle, rsp_valid with rsp_resp 00 and rsp_timeout 0 at cycle 3; cmd_ready low cycles 1-2.
- Read addr 0x10, slave returns RDATA 0xDEADBEEF, RRESP 2'b11 → rsp_rdata 0xDEADBEEF, rsp_resp 11, single rsp_valid pulse.
- Write with AWREADY at cycle 1 and WREADY delayed to cycle 4 → M_AWVALID drops after cycle 1, M_WVALID held through cycle 4, then WR_RESP entered.
- Read with ARREADY never asserted, TIMEOUT_CYCLES=8 → M_ARVALID high 7 cycles then cleared; rsp_valid with rsp_timeout 1, rsp_resp 10, rsp_rdata 0; next command accepted.
- ARESETN low during RD_RESP → next edge all outputs 0, no rsp_valid; after release, cmd_ready=1 and a read completes normally.
- Back-to-back: cmd_valid held high with a second read → second command accepted in the rsp_valid cycle of the first.

Source files
------------

// File: rtl/axi4_lite_master_ctrl_if.sv
`timescale 1ns/1ps
// Requester command/response bundle plus the AXI4-Lite master channels.
// "master" is the controller's view; "slave" is the requester-and-memory view.
interface axi4_lite_master_ctrl_if #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDRESS-1:0]    cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [3:0]            cmd_wstrb;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]            rsp_resp;
  logic                  rsp_timeout;

  logic [ADDRESS-1:0]    M_AWADDR;
  logic                  M_AWVALID;
  logic                  M_AWREADY;
  logic [DATA_WIDTH-1:0] M_WDATA;
  logic [3:0]            M_WSTRB;
  logic                  M_WVALID;
  logic                  M_WREADY;
  logic [1:0]            M_BRESP;
  logic                  M_BVALID;
  logic                  M_BREADY;
  logic [ADDRESS-1:0]    M_ARADDR;
  logic                  M_ARVALID;
  logic                  M_ARREADY;
  logic [DATA_WIDTH-1:0] M_RDATA;
  logic [1:0]            M_RRESP;
  logic                  M_RVALID;
  logic                  M_RREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
    output M_ARADDR, M_ARVALID, M_RREADY,
    input  M_AWREADY, M_WREADY, M_BRESP, M_BVALID,
    input  M_ARREADY, M_RDATA, M_RRESP, M_RVALID
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
    input  M_ARADDR, M_ARVALID, M_RREADY,
    output M_AWREADY, M_WREADY, M_BRESP, M_BVALID,
    output M_ARREADY, M_RDATA, M_RRESP, M_RVALID
  );
endinterface

// File: rtl/axi4_lite_master_ctrl.sv
`timescale 1ns/1ps
// Single-outstanding AXI4-Lite master: one command in, one rsp_valid pulse out (3 cycles best case).
// No response backpressure; cmd_ready is low until the transaction completes or times out.
module axi4_lite_master_ctrl #(
  parameter int ADDRESS        = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  axi4_lite_master_ctrl_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_rsp_valid;
  logic                  r_rsp_timeout;
  logic [1:0]            r_rsp_resp;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDRESS-1:0]    r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_wstrb;

  state_t                w_state_nxt;
  logic                  w_awvalid_nxt;
  logic                  w_wvalid_nxt;
  logic                  w_bready_nxt;
  logic                  w_arvalid_nxt;
  logic                  w_rready_nxt;
  logic                  w_rsp_valid_nxt;
  logic                  w_rsp_timeout_nxt;
  logic [1:0]            w_rsp_resp_nxt;
  logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [ADDRESS-1:0]    w_addr_nxt;
  logic [DATA_WIDTH-1:0] w_wdata_nxt;
  logic [3:0]            w_wstrb_nxt;

  logic                  w_cmd_ready;
  logic                  w_accept;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_expire;
  logic                  w_aw_done;
  logic                  w_w_done;
  logic                  w_abort;

  assign w_cmd_ready = ARESETN && (r_state == IDLE);
  assign w_accept    = bus.cmd_valid && w_cmd_ready;
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  // Fires on the edge where the counter would reach TIMEOUT_CYCLES-1.
  assign w_expire    = (w_cnt_inc == CNT_LAST);
  assign w_aw_done   = !r_awvalid || bus.M_AWREADY;
  assign w_w_done    = !r_wvalid  || bus.M_WREADY;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state       <= IDLE;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_resp    <= 2'b00;
      r_rsp_rdata   <= '0;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= 4'h0;
    end else begin
      r_state       <= w_state_nxt;
      r_awvalid     <= w_awvalid_nxt;
      r_wvalid      <= w_wvalid_nxt;
      r_bready      <= w_bready_nxt;
      r_arvalid     <= w_arvalid_nxt;
      r_rready      <= w_rready_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
      r_rsp_resp    <= w_rsp_resp_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_cnt         <= w_cnt_nxt;
      r_addr        <= w_addr_nxt;
      r_wdata       <= w_wdata_nxt;
      r_wstrb       <= w_wstrb_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_awvalid_nxt     = r_awvalid;
    w_wvalid_nxt      = r_wvalid;
    w_bready_nxt      = r_bready;
    w_arvalid_nxt     = r_arvalid;
    w_rready_nxt      = r_rready;
    w_rsp_valid_nxt   = 1'b0;
    w_rsp_timeout_nxt = 1'b0;
    w_rsp_resp_nxt    = r_rsp_resp;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_cnt_nxt         = r_cnt;
    w_addr_nxt        = r_addr;
    w_wdata_nxt       = r_wdata;
    w_wstrb_nxt       = r_wstrb;
    w_abort           = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_addr_nxt  = bus.cmd_addr;
          w_wdata_nxt = bus.cmd_wdata;
          w_wstrb_nxt = bus.cmd_wstrb;
          w_cnt_nxt   = '0;
          if (bus.cmd_write) begin
            w_state_nxt   = WR_REQ;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
          end else begin
            w_state_nxt   = RD_REQ;
            w_arvalid_nxt = 1'b1;
          end
        end
      end

      WR_REQ: begin
        w_cnt_nxt     = w_cnt_inc;
        w_awvalid_nxt = r_awvalid && !bus.M_AWREADY;
        w_wvalid_nxt  = r_wvalid  && !bus.M_WREADY;
        if (w_aw_done && w_w_done) begin
          w_state_nxt  = WR_RESP;
          w_bready_nxt = 1'b1;
        end
        w_abort = w_expire;
      end

      WR_RESP: begin
        w_cnt_nxt = w_cnt_inc;
        if (bus.M_BVALID) begin
          w_state_nxt     = IDLE;
          w_bready_nxt    = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_resp_nxt  = bus.M_BRESP;
          w_rsp_rdata_nxt = '0;
        end else begin
          w_abort = w_expire;
        end
      end

      RD_REQ: begin
        w_cnt_nxt     = w_cnt_inc;
        w_arvalid_nxt = r_arvalid && !bus.M_ARREADY;
        if (bus.M_ARREADY) begin
          w_state_nxt  = RD_RESP;
          w_rready_nxt = 1'b1;
        end
        w_abort = w_expire;
      end

      RD_RESP: begin
        w_cnt_nxt = w_cnt_inc;
        // A response landing on the expiry edge still completes normally.
        if (bus.M_RVALID) begin
          w_state_nxt     = IDLE;
          w_rready_nxt    = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_resp_nxt  = bus.M_RRESP;
          w_rsp_rdata_nxt = bus.M_RDATA;
        end else begin
          w_abort = w_expire;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_abort) begin
      w_state_nxt       = IDLE;
      w_awvalid_nxt     = 1'b0;
      w_wvalid_nxt      = 1'b0;
      w_bready_nxt      = 1'b0;
      w_arvalid_nxt     = 1'b0;
      w_rready_nxt      = 1'b0;
      w_rsp_valid_nxt   = 1'b1;
      w_rsp_timeout_nxt = 1'b1;
      w_rsp_resp_nxt    = RESP_SLVERR;
      w_rsp_rdata_nxt   = '0;
      w_cnt_nxt         = '0;
    end
  end

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.rsp_resp    = r_rsp_resp;
  assign bus.rsp_rdata   = r_rsp_rdata;

  assign bus.M_AWADDR  = r_addr;
  assign bus.M_AWVALID = r_awvalid;
  assign bus.M_WDATA   = r_wdata;
  assign bus.M_WSTRB   = r_wstrb;
  assign bus.M_WVALID  = r_wvalid;
  assign bus.M_BREADY  = r_bready;
  assign bus.M_ARADDR  = r_addr;
  assign bus.M_ARVALID = r_arvalid;
  assign bus.M_RREADY  = r_rready;
endmodule

// File: tb/tb_axi4_lite_master_ctrl.sv
`timescale 1ns/1ps
// Directed bench for axi4_lite_master_ctrl with TIMEOUT_CYCLES=8; inputs driven and
// outputs sampled on the falling edge, cycle N = N rising edges after acceptance.
module tb_axi4_lite_master_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic ACLK    = 1'b0;
  logic ARESETN = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  axi4_lite_master_ctrl_if #(.ADDRESS(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_master_ctrl #(
    .ADDRESS(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus)
  );

  always #5 ACLK = ~ACLK;

  // {cmd_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_timeout}
  logic [7:0] obs_flags;
  assign obs_flags = {bus.cmd_ready, bus.M_AWVALID, bus.M_WVALID, bus.M_BREADY,
                      bus.M_ARVALID, bus.M_RREADY, bus.rsp_valid, bus.rsp_timeout};

  task automatic tick();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic slave_idle();
    bus.M_AWREADY = 1'b0; bus.M_WREADY = 1'b0;
    bus.M_BVALID  = 1'b0; bus.M_BRESP  = 2'b00;
    bus.M_ARREADY = 1'b0; bus.M_RVALID = 1'b0;
    bus.M_RDATA   = '0;   bus.M_RRESP  = 2'b00;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.cmd_valid = 1'b1; bus.cmd_write = wr;
    bus.cmd_addr  = a;    bus.cmd_wdata = d; bus.cmd_wstrb = s;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if (obs_flags !== 8'h00) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000000", obs_flags);
    end
    checks++;
    if ({bus.rsp_resp, bus.rsp_rdata, bus.M_AWADDR, bus.M_WDATA, bus.M_WSTRB} !== 102'd0) begin
      errors++; $display("FAIL reset_regs: resp %b rdata %h addr %h wdata %h wstrb %h expected all 0",
                         bus.rsp_resp, bus.rsp_rdata, bus.M_AWADDR, bus.M_WDATA, bus.M_WSTRB);
    end
    ARESETN = 1'b1;
    #1;
    checks++;
    if (obs_flags !== 8'b1000_0000) begin
      errors++; $display("FAIL reset_release: got %b expected 10000000", obs_flags);
    end
  endtask

  task automatic test_write_basic();
    logic [7:0] exp_f [4];
    exp_f = '{8'b0110_0000, 8'b0001_0000, 8'b1000_0010, 8'b1000_0000};
    slave_idle();
    bus.M_AWREADY = 1'b1; bus.M_WREADY = 1'b1; bus.M_BVALID = 1'b1; bus.M_BRESP = 2'b00;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    tick();
    bus.cmd_valid = 1'b0;
    checks++;
    if ({bus.M_AWADDR, bus.M_WDATA, bus.M_WSTRB} !== {32'h10, 32'hDEADBEEF, 4'hF}) begin
      errors++; $display("FAIL wr_basic_payload: got %h/%h/%h expected 00000010/deadbeef/f",
                         bus.M_AWADDR, bus.M_WDATA, bus.M_WSTRB);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_flags !== exp_f[k]) begin
        errors++; $display("FAIL wr_basic_flags cycle %0d: got %b expected %b", k + 1, obs_flags, exp_f[k]);
      end
      if (k == 2) begin
        checks++;
        if ({bus.rsp_resp, bus.rsp_rdata} !== {2'b00, 32'h0}) begin
          errors++; $display("FAIL wr_basic_rsp: got resp %b rdata %h expected 00 00000000", bus.rsp_resp, bus.rsp_rdata);
        end
      end
      tick();
    end
    slave_idle();
  endtask

  task automatic test_read_basic();
    logic [7:0] exp_f [4];
    exp_f = '{8'b0000_1000, 8'b0000_0100, 8'b1000_0010, 8'b1000_0000};
    slave_idle();
    bus.M_ARREADY = 1'b1; bus.M_RVALID = 1'b1; bus.M_RDATA = 32'hDEADBEEF; bus.M_RRESP = 2'b11;
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.M_ARADDR !== 32'h10) begin
      errors++; $display("FAIL rd_basic_araddr: got %h expected 00000010", bus.M_ARADDR);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_flags !== exp_f[k]) begin
        errors++; $display("FAIL rd_basic_flags cycle %0d: got %b expected %b", k + 1, obs_flags, exp_f[k]);
      end
      if (k == 2) begin
        checks++;
        if ({bus.rsp_resp, bus.rsp_rdata} !== {2'b11, 32'hDEADBEEF}) begin
          errors++; $display("FAIL rd_basic_rsp: got resp %b rdata %h expected 11 deadbeef", bus.rsp_resp, bus.rsp_rdata);
        end
      end
      tick();
    end
    slave_idle();
  endtask

  task automatic test_write_delayed_w();
    logic [7:0] exp_f [7];
    exp_f = '{8'b0110_0000, 8'b0010_0000, 8'b0010_0000, 8'b0010_0000,
              8'b0001_0000, 8'b1000_0010, 8'b1000_0000};
    slave_idle();
    bus.M_AWREADY = 1'b1; bus.M_BVALID = 1'b1; bus.M_BRESP = 2'b01;
    issue(1'b1, 32'h24, 32'h12345678, 4'h3);
    tick();
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (obs_flags !== exp_f[k]) begin
        errors++; $display("FAIL wr_delay_flags cycle %0d: got %b expected %b", k + 1, obs_flags, exp_f[k]);
      end
      if (k == 3) begin
        checks++;
        if ({bus.M_AWADDR, bus.M_WDATA, bus.M_WSTRB} !== {32'h24, 32'h12345678, 4'h3}) begin
          errors++; $display("FAIL wr_delay_payload: got %h/%h/%h expected 00000024/12345678/3",
                             bus.M_AWADDR, bus.M_WDATA, bus.M_WSTRB);
        end
        bus.M_WREADY = 1'b1;
      end
      if (k == 5) begin
        checks++;
        if ({bus.rsp_resp, bus.rsp_rdata} !== {2'b01, 32'h0}) begin
          errors++; $display("FAIL wr_delay_rsp: got resp %b rdata %h expected 01 00000000", bus.rsp_resp, bus.rsp_rdata);
        end
      end
      tick();
    end
    slave_idle();
  endtask

  task automatic test_timeout();
    logic [7:0] exp_f;
    slave_idle();
    issue(1'b0, 32'h50, 32'h0, 4'h0);
    tick();
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      exp_f = (k < 7) ? 8'b0000_1000 : ((k == 7) ? 8'b1000_0011 : 8'b1000_0000);
      checks++;
      if (obs_flags !== exp_f) begin
        errors++; $display("FAIL timeout_flags cycle %0d: got %b expected %b", k + 1, obs_flags, exp_f);
      end
      if (k == 7) begin
        checks++;
        if ({bus.rsp_resp, bus.rsp_rdata} !== {2'b10, 32'h0}) begin
          errors++; $display("FAIL timeout_rsp: got resp %b rdata %h expected 10 00000000", bus.rsp_resp, bus.rsp_rdata);
        end
      end
      if (k < 8) tick();
    end
    bus.M_ARREADY = 1'b1; bus.M_RVALID = 1'b1; bus.M_RDATA = 32'hCAFEF00D; bus.M_RRESP = 2'b00;
    issue(1'b0, 32'h80, 32'h0, 4'h0);
    tick();
    bus.cmd_valid = 1'b0;
    checks++;
    if (obs_flags !== 8'b0000_1000) begin
      errors++; $display("FAIL timeout_next_accept: got %b expected 00001000", obs_flags);
    end
    tick(); tick();
    checks++;
    if ({obs_flags, bus.rsp_rdata} !== {8'b1000_0010, 32'hCAFEF00D}) begin
      errors++; $display("FAIL timeout_next_rsp: got %b/%h expected 10000010/cafef00d", obs_flags, bus.rsp_rdata);
    end
    tick();
    slave_idle();
  endtask

  task automatic test_timeout_coincide();
    logic [7:0] exp_f;
    slave_idle();
    bus.M_ARREADY = 1'b1;
    issue(1'b0, 32'h90, 32'h0, 4'h0);
    tick();
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_f = (k == 0) ? 8'b0000_1000 : ((k < 7) ? 8'b0000_0100 : 8'b1000_0010);
      checks++;
      if (obs_flags !== exp_f) begin
        errors++; $display("FAIL coincide_flags cycle %0d: got %b expected %b", k + 1, obs_flags, exp_f);
      end
      if (k == 6) begin
        bus.M_RVALID = 1'b1; bus.M_RDATA = 32'h0BADF00D; bus.M_RRESP = 2'b01;
      end
      if (k == 7) begin
        checks++;
        if ({bus.rsp_resp, bus.rsp_rdata} !== {2'b01, 32'h0BADF00D}) begin
          errors++; $display("FAIL coincide_rsp: got resp %b rdata %h expected 01 0badf00d", bus.rsp_resp, bus.rsp_rdata);
        end
      end
      tick();
    end
    slave_idle();
  endtask

  task automatic test_reset_mid();
    slave_idle();
    bus.M_ARREADY = 1'b1;
    issue(1'b0, 32'h30, 32'h0, 4'h0);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    checks++;
    if (obs_flags !== 8'b0000_0100) begin
      errors++; $display("FAIL rstmid_in_rresp: got %b expected 00000100", obs_flags);
    end
    ARESETN = 1'b0;
    bus.M_RVALID = 1'b1; bus.M_RDATA = 32'h55; bus.M_RRESP = 2'b01;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_cmd_ready: got %b expected 0", bus.cmd_ready);
    end
    tick();
    checks++;
    if ({obs_flags, bus.rsp_resp, bus.rsp_rdata, bus.M_ARADDR} !== 74'd0) begin
      errors++; $display("FAIL rstmid_cleared: flags %b resp %b rdata %h araddr %h expected all 0",
                         obs_flags, bus.rsp_resp, bus.rsp_rdata, bus.M_ARADDR);
    end
    tick();
    checks++;
    if (obs_flags !== 8'h00) begin
      errors++; $display("FAIL rstmid_no_rsp: got %b expected 00000000", obs_flags);
    end
    ARESETN = 1'b1;
    bus.M_RVALID = 1'b0;
    #1;
    checks++;
    if (obs_flags !== 8'b1000_0000) begin
      errors++; $display("FAIL rstmid_release: got %b expected 10000000", obs_flags);
    end
    bus.M_RVALID = 1'b1; bus.M_RDATA = 32'hA5A50001; bus.M_RRESP = 2'b00;
    issue(1'b0, 32'h34, 32'h0, 4'h0);
    tick();
    bus.cmd_valid = 1'b0;
    checks++;
    if ({obs_flags, bus.M_ARADDR} !== {8'b0000_1000, 32'h34}) begin
      errors++; $display("FAIL rstmid_after_ar: got %b/%h expected 00001000/00000034", obs_flags, bus.M_ARADDR);
    end
    tick(); tick();
    checks++;
    if ({obs_flags, bus.rsp_resp, bus.rsp_rdata} !== {8'b1000_0010, 2'b00, 32'hA5A50001}) begin
      errors++; $display("FAIL rstmid_after_rsp: got %b/%b/%h expected 10000010/00/a5a50001",
                         obs_flags, bus.rsp_resp, bus.rsp_rdata);
    end
    tick();
    slave_idle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_f [7];
    exp_f = '{8'b0000_1000, 8'b0000_0100, 8'b1000_0010,
              8'b0000_1000, 8'b0000_0100, 8'b1000_0010, 8'b1000_0000};
    slave_idle();
    bus.M_ARREADY = 1'b1; bus.M_RVALID = 1'b1; bus.M_RDATA = 32'h11112222; bus.M_RRESP = 2'b00;
    issue(1'b0, 32'h40, 32'h0, 4'h0);
    tick();
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (obs_flags !== exp_f[k]) begin
        errors++; $display("FAIL b2b_flags cycle %0d: got %b expected %b", k + 1, obs_flags, exp_f[k]);
      end
      if (k == 2) begin
        checks++;
        if (bus.rsp_rdata !== 32'h11112222) begin
          errors++; $display("FAIL b2b_first_rdata: got %h expected 11112222", bus.rsp_rdata);
        end
        bus.cmd_addr = 32'h44;
        bus.M_RDATA  = 32'h33334444;
      end
      if (k == 3) begin
        checks++;
        if (bus.M_ARADDR !== 32'h44) begin
          errors++; $display("FAIL b2b_second_addr: got %h expected 00000044", bus.M_ARADDR);
        end
        bus.cmd_valid = 1'b0;
      end
      if (k == 5) begin
        checks++;
        if (bus.rsp_rdata !== 32'h33334444) begin
          errors++; $display("FAIL b2b_second_rdata: got %h expected 33334444", bus.rsp_rdata);
        end
      end
      tick();
    end
    slave_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0;   bus.cmd_wstrb = 4'h0;
    slave_idle();
    @(negedge ACLK);
    test_reset();
    test_write_basic();
    test_read_basic();
    test_write_delayed_w();
    test_timeout();
    test_timeout_coincide();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
